riscvio2i_core_scoreboard: RTL and testbench

- Issue-stage scheduler for the in-order-issue / out-of-order-writeback RISC-V core.
- Tracks pending destination registers and when they will be written back. Detects RAW, WAW and writeback-port structural hazards for the instruction in decode.
- Drives the single shared writeback port: valid, rd and result-source select each cycle.
- Fed with decoded rs1/rs2/rd fields of the instruction message plus a functional-unit tag.

---
 rtl/riscvio2i_core_scoreboard_pkg.sv | 22 ++
 rtl/riscvio2i_core_wb_reservation.sv | 55 +++++
 rtl/riscvio2i_core_scoreboard.sv | 101 ++++++++++
 tb/tb_riscvio2i_core_scoreboard.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/riscvio2i_core_scoreboard_pkg.sv
// riscvio2i_core_scoreboard_pkg: shared encodings, widths and default latencies for the issue scoreboard.
package riscvio2i_core_scoreboard_pkg;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MEM = 2'd1,
        FU_MUL = 2'd2,
        FU_RSV = 2'd3
    } fu_e;

    localparam int CNT_W       = 3;
    localparam int RSV_DEPTH   = 5;
    localparam int DEF_ALU_LAT = 1;
    localparam int DEF_MEM_LAT = 2;
    localparam int DEF_MUL_LAT = 4;

    // The reserved encoding behaves like an ALU op.
    function automatic logic [CNT_W-1:0] fu_lat(input logic [1:0] fu, input int alu, input int mem, input int mul);
        return (fu == FU_MEM) ? CNT_W'(mem) : (fu == FU_MUL) ? CNT_W'(mul) : CNT_W'(alu);
    endfunction

endpackage

// File: rtl/riscvio2i_core_wb_reservation.sv
// riscvio2i_core_wb_reservation: writeback-port booking shift register; slot k is the port k cycles from now.
module riscvio2i_core_wb_reservation
    import riscvio2i_core_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_i,
    input  logic [CNT_W-1:0]     set_slot_i,
    input  logic [4:0]           set_rd_i,
    input  logic [1:0]           set_fu_i,
    output logic [RSV_DEPTH-1:0] busy_o,
    output logic                 wb_val_o,
    output logic [4:0]           wb_rd_o,
    output logic [1:0]           wb_fu_o
);

    logic [RSV_DEPTH-1:0] rsv_q, rsv_d;
    logic [4:0]           rd_q [RSV_DEPTH];
    logic [4:0]           rd_d [RSV_DEPTH];
    logic [1:0]           fu_q [RSV_DEPTH];
    logic [1:0]           fu_d [RSV_DEPTH];

    always_comb begin
        rsv_d = rsv_q >> 1;
        for (int k = 0; k < RSV_DEPTH - 1; k++) begin
            rd_d[k] = rd_q[k+1];
            fu_d[k] = fu_q[k+1];
        end
        rd_d[RSV_DEPTH-1] = '0;
        fu_d[RSV_DEPTH-1] = '0;
        if (set_i) begin
            rsv_d[set_slot_i] = 1'b1;
            rd_d[set_slot_i]  = set_rd_i;
            fu_d[set_slot_i]  = set_fu_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsv_q <= '0;
            rd_q  <= '{default: '0};
            fu_q  <= '{default: '0};
        end else begin
            rsv_q <= rsv_d;
            rd_q  <= rd_d;
            fu_q  <= fu_d;
        end
    end

    assign busy_o   = rsv_q;
    assign wb_val_o = rsv_q[0];
    assign wb_rd_o  = rsv_q[0] ? rd_q[0] : '0;
    assign wb_fu_o  = rsv_q[0] ? fu_q[0] : '0;

endmodule

// File: rtl/riscvio2i_core_scoreboard.sv
// riscvio2i_core_scoreboard: in-order issue scheduler tracking pending destinations and the shared writeback port.
module riscvio2i_core_scoreboard
    import riscvio2i_core_scoreboard_pkg::*;
#(
    parameter int ALU_LAT = DEF_ALU_LAT,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_val,
    input  logic [1:0] issue_fu,
    input  logic [4:0] rs1,
    input  logic       rs1_en,
    input  logic [4:0] rs2,
    input  logic       rs2_en,
    input  logic [4:0] rd,
    input  logic       rd_en,
    output logic       stall,
    output logic       stall_raw,
    output logic       stall_waw,
    output logic       stall_struct,
    output logic       rs1_byp,
    output logic       rs2_byp,
    output logic       wb_val,
    output logic [4:0] wb_rd,
    output logic [1:0] wb_fu
);

    logic [31:0]          pend_q, pend_d;
    logic [CNT_W-1:0]     cnt_q [32];
    logic [CNT_W-1:0]     cnt_d [32];
    logic [CNT_W-1:0]     lat, slot;
    logic [RSV_DEPTH-1:0] busy;
    logic                 writes, s1_hit, s2_hit, s1_now, s2_now, raw, waw, strct, wr_fire;
    logic                 wbv;
    logic [4:0]           wbr;
    logic [1:0]           wbf;

    assign lat    = fu_lat(issue_fu, ALU_LAT, MEM_LAT, MUL_LAT);
    assign slot   = lat - 1'b1;
    assign writes = rd_en && rd != 5'd0;

    // A source whose producer writes back this cycle is taken from the bus instead of stalling.
    assign s1_hit = rs1_en && rs1 != 5'd0 && pend_q[rs1];
    assign s2_hit = rs2_en && rs2 != 5'd0 && pend_q[rs2];
    assign s1_now = cnt_q[rs1] == '0;
    assign s2_now = cnt_q[rs2] == '0;
    assign raw    = (s1_hit && !s1_now) || (s2_hit && !s2_now);
    assign waw    = writes && pend_q[rd] && cnt_q[rd] >= slot;
    assign strct  = writes && busy[lat];

    assign stall_raw    = !reset && raw;
    assign stall_waw    = !reset && waw;
    assign stall_struct = !reset && strct;
    assign stall        = stall_raw || stall_waw || stall_struct;
    assign rs1_byp      = !reset && s1_hit && s1_now;
    assign rs2_byp      = !reset && s2_hit && s2_now;
    assign wr_fire      = issue_val && !stall && !reset && writes;

    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        for (int r = 1; r < 32; r++) begin
            pend_d[r] = pend_q[r] && cnt_q[r] != '0;
            cnt_d[r]  = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : cnt_q[r];
        end
        if (wr_fire) begin
            pend_d[rd] = 1'b1;
            cnt_d[rd]  = slot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            cnt_q  <= '{default: '0};
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    riscvio2i_core_wb_reservation u_rsv (
        .clk        (clk),
        .reset      (reset),
        .set_i      (wr_fire),
        .set_slot_i (slot),
        .set_rd_i   (rd),
        .set_fu_i   (issue_fu),
        .busy_o     (busy),
        .wb_val_o   (wbv),
        .wb_rd_o    (wbr),
        .wb_fu_o    (wbf)
    );

    assign wb_val = !reset && wbv;
    assign wb_rd  = reset ? 5'd0 : wbr;
    assign wb_fu  = reset ? 2'd0 : wbf;

endmodule

// File: tb/tb_riscvio2i_core_scoreboard.sv
// tb_riscvio2i_core_scoreboard: directed scenarios checked against an absolute-time booking model plus literal spot checks.
module tb_riscvio2i_core_scoreboard;

    logic       clk = 1'b0, reset = 1'b1;
    logic       issue_val, rs1_en, rs2_en, rd_en;
    logic [1:0] issue_fu;
    logic [4:0] rs1, rs2, rd;
    logic       stall, stall_raw, stall_waw, stall_struct, rs1_byp, rs2_byp, wb_val;
    logic [4:0] wb_rd;
    logic [1:0] wb_fu;

    riscvio2i_core_scoreboard dut (
        .clk(clk), .reset(reset), .issue_val(issue_val), .issue_fu(issue_fu),
        .rs1(rs1), .rs1_en(rs1_en), .rs2(rs2), .rs2_en(rs2_en), .rd(rd), .rd_en(rd_en),
        .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw), .stall_struct(stall_struct),
        .rs1_byp(rs1_byp), .rs2_byp(rs2_byp), .wb_val(wb_val), .wb_rd(wb_rd), .wb_fu(wb_fu)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    // Model: absolute cycle at which each register's youngest writer writes back, and port bookings per cycle.
    int wb_time[32] = '{default: -1};
    int book_rd[int];
    int book_fu[int];

    function automatic int lat_of(input logic [1:0] f);
        return f == 2'd1 ? 2 : f == 2'd2 ? 4 : 1;
    endfunction

    function automatic logic waits(input logic en, input logic [4:0] s);
        return en && s != 0 && wb_time[s] > cyc;
    endfunction

    function automatic logic on_bus(input logic en, input logic [4:0] s);
        return en && s != 0 && wb_time[s] == cyc;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int l, e_rd, e_fu;
        logic w, e_raw, e_waw, e_st, e_wv, e_stall;
        l       = lat_of(issue_fu);
        w       = rd_en && rd != 0;
        e_raw   = !reset && (waits(rs1_en, rs1) || waits(rs2_en, rs2));
        e_waw   = !reset && w && wb_time[rd] >= cyc && wb_time[rd] - cyc >= l - 1;
        e_st    = !reset && w && book_rd.exists(cyc + l);
        e_stall = e_raw || e_waw || e_st;
        e_wv    = !reset && book_rd.exists(cyc);
        e_rd    = e_wv ? book_rd[cyc] : 0;
        e_fu    = e_wv ? book_fu[cyc] : 0;
        cmp("m_stall", stall, e_stall);
        cmp("m_raw", stall_raw, e_raw);
        cmp("m_waw", stall_waw, e_waw);
        cmp("m_struct", stall_struct, e_st);
        cmp("m_byp1", rs1_byp, !reset && on_bus(rs1_en, rs1));
        cmp("m_byp2", rs2_byp, !reset && on_bus(rs2_en, rs2));
        cmp("m_wb_val", wb_val, e_wv);
        cmp("m_wb_rd", wb_rd, e_rd);
        cmp("m_wb_fu", wb_fu, e_fu);
        if (reset) begin
            wb_time = '{default: -1};
            book_rd.delete();
            book_fu.delete();
        end else if (issue_val && !e_stall && w) begin
            wb_time[rd]      = cyc + l;
            book_rd[cyc + l] = rd;
            book_fu[cyc + l] = issue_fu;
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] f, input logic [4:0] a, input logic ae,
                       input logic [4:0] b, input logic be, input logic [4:0] d, input logic de);
        issue_val = v; issue_fu = f; rs1 = a; rs1_en = ae; rs2 = b; rs2_en = be; rd = d; rd_en = de;
    endtask

    task automatic idle;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        repeat (2) tick();
        #3 cmp("rst_wb_val", wb_val, 0);
        cmp("rst_stall", stall, 0);
        reset = 1'b0;
        tick();
        // ALU back-to-back with bypass
        drv(1, 0, 0, 0, 0, 0, 4, 1);
        #3 cmp("alu_t0_stall", stall, 0);
        tick();
        drv(1, 0, 4, 1, 0, 0, 8, 1);
        #3 cmp("alu_t1_stall", stall, 0);
        cmp("alu_t1_byp", rs1_byp, 1);
        cmp("alu_t1_wb_val", wb_val, 1);
        cmp("alu_t1_wb_rd", wb_rd, 4);
        cmp("alu_t1_wb_fu", wb_fu, 0);
        tick(); idle(); repeat (5) tick();
        // MUL RAW
        drv(1, 2, 0, 0, 0, 0, 5, 1);
        tick();
        drv(1, 0, 0, 0, 5, 1, 10, 1);
        for (int i = 0; i < 3; i++) begin
            #3 cmp("mul_raw_wait", stall_raw, 1);
            tick();
        end
        #3 cmp("mul_raw_go", stall, 0);
        cmp("mul_raw_byp2", rs2_byp, 1);
        cmp("mul_raw_wb_rd", wb_rd, 5);
        cmp("mul_raw_wb_fu", wb_fu, 2);
        tick(); idle(); repeat (5) tick();
        // structural: load collides with MUL writeback slot
        drv(1, 2, 0, 0, 0, 0, 6, 1);
        tick(); idle(); tick();
        drv(1, 1, 0, 0, 0, 0, 7, 1);
        #3 cmp("st_t2_struct", stall_struct, 1);
        tick();
        #3 cmp("st_t3_stall", stall, 0);
        tick(); idle();
        #3 cmp("st_t4_wb_rd", wb_rd, 6);
        tick();
        #3 cmp("st_t5_wb_val", wb_val, 1);
        cmp("st_t5_wb_rd", wb_rd, 7);
        cmp("st_t5_wb_fu", wb_fu, 1);
        tick(); repeat (4) tick();
        // WAW: load re-targets the MUL destination, firing as the MUL writes back
        drv(1, 2, 0, 0, 0, 0, 9, 1);
        tick();
        drv(1, 1, 0, 0, 0, 0, 9, 1);
        for (int i = 0; i < 3; i++) begin
            #3 cmp("waw_wait", stall_waw, 1);
            tick();
        end
        #3 cmp("waw_go", stall, 0);
        cmp("waw_t4_wb_rd", wb_rd, 9);
        cmp("waw_t4_wb_fu", wb_fu, 2);
        tick();
        drv(1, 0, 9, 1, 9, 1, 0, 0);
        #3 cmp("waw_set_wins", stall_raw, 1);
        tick();
        #3 cmp("waw_t6_stall", stall, 0);
        cmp("waw_t6_byp1", rs1_byp, 1);
        cmp("waw_t6_byp2", rs2_byp, 1);
        cmp("waw_t6_wb_rd", wb_rd, 9);
        cmp("waw_t6_wb_fu", wb_fu, 1);
        tick(); idle(); repeat (3) tick();
        // x0 destination and store during MUL flight
        drv(1, 2, 0, 0, 0, 0, 11, 1);
        tick();
        drv(1, 0, 0, 1, 0, 1, 0, 1);
        #3 cmp("x0_stall", stall, 0);
        cmp("x0_byp1", rs1_byp, 0);
        tick();
        drv(1, 1, 1, 1, 2, 1, 11, 0);
        #3 cmp("sw_stall", stall, 0);
        tick(); idle();
        #3 cmp("x0_t3_wb_val", wb_val, 0);
        tick();
        #3 cmp("x0_t4_wb_val", wb_val, 1);
        cmp("x0_t4_wb_rd", wb_rd, 11);
        tick();
        #3 cmp("x0_t5_wb_val", wb_val, 0);
        tick(); repeat (2) tick();
        // reset mid-flight, with an issue attempt during reset
        drv(1, 2, 0, 0, 0, 0, 3, 1);
        tick();
        reset = 1'b1;
        drv(1, 2, 0, 0, 0, 0, 13, 1);
        #3 cmp("rm_t1_wb_val", wb_val, 0);
        cmp("rm_t1_stall", stall, 0);
        tick();
        reset = 1'b0;
        idle();
        #3 cmp("rm_t2_wb_val", wb_val, 0);
        tick();
        drv(1, 0, 3, 1, 0, 0, 0, 0);
        #3 cmp("rm_t3_stall", stall, 0);
        cmp("rm_t3_byp1", rs1_byp, 0);
        tick(); idle();
        #3 cmp("rm_t4_wb_val", wb_val, 0);
        tick(); repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
